uart_frame_debugger: RTL and testbench
======================================

Name: uart_frame_debugger

Overview:
Debug/observation block on the UART receive path. Captures every frame presented by the UART receiver (8 data bits plus 1 parity bit) and holds the last captured frame on a stable output for LEDs or a logic analyser. Also checks parity, counts frames and parity errors, and keeps a sticky error flag. Purely observational; it never back-pressures the receiver.

Parameters:
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity for the parity check.
CNT_W, 16, width of the frame and error counters.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  reset, synchronous, active-high.
frame  input  9  received frame; bit 8 is the parity bit, bits 7:0 are the data byte.
frame_valid  input  1  frame qualifier; frame is sampled on every rising edge where this is high.
debug_frame  output  9  last captured frame, registered.
frame_strobe  output  1  one-cycle pulse in the cycle debug_frame takes a new value.
parity_ok  output  1  parity result of the frame currently on debug_frame (1 = correct).
parity_err_sticky  output  1  set on any parity error, cleared only by rst.
frame_count  output  CNT_W  number of frames captured since reset, saturating.
err_count  output  CNT_W  number of parity-error frames since reset, saturating.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All state is updated only on clk rising edges.
- Reset values: debug_frame = 0, frame_strobe = 0, parity_ok = 1, parity_err_sticky = 0, frame_count = 0, err_count = 0.
- rst has priority over frame_valid in the same cycle; no capture occurs in that cycle.
- Capture: on a rising edge with rst = 0 and frame_valid = 1:
  - debug_frame <= frame.
  - frame_strobe <= 1.
  - parity_ok <= computed result.
  - Latency is 1 cycle: outputs reflect the new frame from the edge at which it was sampled.
- Level-qualified sampling: frame_valid held high for N cycles captures N frames. Each captured frame counts, strobes and is parity-checked.
- No capture when frame_valid = 0: debug_frame and parity_ok hold their values, frame_strobe <= 0.
- frame is ignored, even if X, whenever frame_valid = 0.
- Parity:
  - expected = XOR(frame[7:0]) when PARITY_ODD = 0, otherwise its inverse.
  - Error when frame[8] != expected.
- On a captured error frame:
  - parity_ok <= 0.
  - parity_err_sticky <= 1.
  - err_count increments.
- frame_count increments on every capture.
- Both counters saturate at all-ones and never wrap.
- A capture in the cycle right after rst deasserts is valid and counted.
- No state machine; the block is a capture register, a combinational parity tree and two saturating counters.

Decomposition:
- Shared package uart_pkg:
  - FRAME_W = 9, DATA_W = 8, PARITY_BIT = 8.
  - Typedef for the 9-bit UART frame (parity, data fields).
- One sub-module, uart_parity_check:
  - Combinational.
  - Inputs: frame and the PARITY_ODD parameter.
  - Output: parity_ok.
  - Reused by the UART receiver.
- Saturating counters are inline logic, not a module.

Test Plan:
- Reset: hold rst 1 cycle -> all outputs at reset values. Drive frame = 9'h1FF with frame_valid = 1 while rst = 1 -> no capture, frame_count stays 0.
- Good frame: frame = 9'b0_1010_1010 (0xAA, parity 0), frame_valid high 1 cycle -> next edge debug_frame = 9'h0AA, frame_strobe pulses 1 cycle, parity_ok = 1, frame_count = 1, err_count = 0.
- Bad frame: ~100 ns later, frame = 9'b0_1011_0011 (0xB3, 5 ones, parity bit 0), frame_valid 1 cycle -> debug_frame = 9'h0B3, parity_ok = 0, parity_err_sticky = 1, frame_count = 2, err_count = 1.
- Hold behaviour: after the bad frame, change frame to 9'h155 with frame_valid = 0 -> debug_frame stays 9'h0B3, no strobe. Then send 0xAA again -> parity_ok = 1, parity_err_sticky stays 1.
- Back-to-back: frame_valid high 3 consecutive cycles with 0x01/p1, 0x02/p1, 0x03/p0 -> debug_frame updates every cycle, frame_strobe high 3 cycles, frame_count += 3, err_count += 0.
- Saturation and odd parity: with CNT_W = 4, send 20 frames -> frame_count = 15. With PARITY_ODD = 1, frame 9'b1_1010_1010 -> parity_ok = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the packed frame layout
// used by the receiver, the parity checker and the frame debugger.
package uart_pkg;

    localparam int FRAME_W    = 9;
    localparam int DATA_W     = 8;
    localparam int PARITY_BIT = 8;

    // Bit 8 carries the parity bit, bits 7:0 carry the data byte.
    typedef struct packed {
        logic              parity;
        logic [DATA_W-1:0] data;
    } uart_frame_t;

endpackage

// File: rtl/uart_parity_check.sv
// Combinational parity checker for one UART frame. Shared with the UART
// receiver so both sides agree on what a good frame is.
module uart_parity_check
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [FRAME_W-1:0] frame,
    output logic               parity_ok
);

    uart_frame_t frame_fields;
    logic        expected_parity;

    // XOR tree over the data byte, inverted for odd parity, then compared with the received parity bit
    always_comb begin
        frame_fields    = uart_frame_t'(frame);
        expected_parity = (^frame_fields.data) ^ PARITY_ODD;
        parity_ok       = (frame_fields.parity == expected_parity);
    end

endmodule

// File: rtl/uart_frame_debugger.sv
// Observation block on the UART receive path: latches the last frame for
// LEDs or a logic analyser, checks its parity and keeps saturating frame
// and parity-error counters plus a sticky error flag. Never stalls the
// receiver; frame is only looked at while frame_valid is high.
module uart_frame_debugger
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic [FRAME_W-1:0] debug_frame,
    output logic               frame_strobe,
    output logic               parity_ok,
    output logic               parity_err_sticky,
    output logic [CNT_W-1:0]   frame_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic frame_parity_ok;

    uart_parity_check #(
        .PARITY_ODD (PARITY_ODD)
    ) u_parity_check (
        .frame     (frame),
        .parity_ok (frame_parity_ok)
    );

    // Capture register, strobe, sticky flag and saturating counters; reset wins over a same-cycle capture
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_frame       <= '0;
            frame_strobe      <= 1'b0;
            parity_ok         <= 1'b1;
            parity_err_sticky <= 1'b0;
            frame_count       <= '0;
            err_count         <= '0;
        end else if (frame_valid) begin
            debug_frame  <= frame;
            frame_strobe <= 1'b1;
            parity_ok    <= frame_parity_ok;
            if (frame_count != CNT_MAX) begin
                frame_count <= frame_count + CNT_ONE;
            end
            if (!frame_parity_ok) begin
                parity_err_sticky <= 1'b1;
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_ONE;
                end
            end
        end else begin
            frame_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_frame_debugger.sv
// Bench for uart_frame_debugger. Two instances share the same stimulus:
// a default one (even parity, 16-bit counters) and a small one (odd parity,
// 4-bit counters) so that saturation is reachable quickly.
module tb_uart_frame_debugger;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_valid;
    logic [8:0] frame;

    logic [8:0]  dbg_a, dbg_b;
    logic        strobe_a, strobe_b;
    logic        ok_a, ok_b;
    logic        sticky_a, sticky_b;
    logic [15:0] fc_a, ec_a;
    logic [3:0]  fc_b, ec_b;

    int compared   = 0;
    int mismatched = 0;

    // Reference state per instance: index 0 = even/16-bit, 1 = odd/4-bit
    logic [8:0] m_frame  [2];
    logic       m_strobe [2];
    logic       m_ok     [2];
    logic       m_sticky [2];
    int         m_fc     [2];
    int         m_ec     [2];
    int         m_max    [2] = '{65535, 15};
    bit         m_odd    [2] = '{1'b0, 1'b1};

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    uart_frame_debugger #(
        .PARITY_ODD (1'b0),
        .CNT_W      (16)
    ) dut_a (
        .clk               (clk),
        .rst               (rst),
        .frame             (frame),
        .frame_valid       (frame_valid),
        .debug_frame       (dbg_a),
        .frame_strobe      (strobe_a),
        .parity_ok         (ok_a),
        .parity_err_sticky (sticky_a),
        .frame_count       (fc_a),
        .err_count         (ec_a)
    );

    uart_frame_debugger #(
        .PARITY_ODD (1'b1),
        .CNT_W      (4)
    ) dut_b (
        .clk               (clk),
        .rst               (rst),
        .frame             (frame),
        .frame_valid       (frame_valid),
        .debug_frame       (dbg_b),
        .frame_strobe      (strobe_b),
        .parity_ok         (ok_b),
        .parity_err_sticky (sticky_b),
        .frame_count       (fc_b),
        .err_count         (ec_b)
    );

    // A frame is good when the count of ones in the data byte, plus one for odd parity, has the parity bit's oddness
    function automatic logic refParityOk(input logic [8:0] f, input bit odd);
        return (f[8] == ((($countones(f[7:0]) % 2) == 1) ^ odd));
    endfunction

    // Advance the reference by one rising edge using the inputs present at that edge
    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_frame[i]  = 9'h000;
                m_strobe[i] = 1'b0;
                m_ok[i]     = 1'b1;
                m_sticky[i] = 1'b0;
                m_fc[i]     = 0;
                m_ec[i]     = 0;
            end else if (frame_valid) begin
                m_frame[i]  = frame;
                m_strobe[i] = 1'b1;
                m_ok[i]     = refParityOk(frame, m_odd[i]);
                m_fc[i]     = (m_fc[i] + 1 > m_max[i]) ? m_max[i] : m_fc[i] + 1;
                if (!m_ok[i]) begin
                    m_sticky[i] = 1'b1;
                    m_ec[i]     = (m_ec[i] + 1 > m_max[i]) ? m_max[i] : m_ec[i] + 1;
                end
            end else begin
                m_strobe[i] = 1'b0;
            end
        end
    endtask

    // Single counted comparison with a failure report
    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output of both instances with the reference
    task automatic checkOutput();
        checkVal("a.debug_frame",       {23'd0, dbg_a},    {23'd0, m_frame[0]});
        checkVal("a.frame_strobe",      {31'd0, strobe_a}, {31'd0, m_strobe[0]});
        checkVal("a.parity_ok",         {31'd0, ok_a},     {31'd0, m_ok[0]});
        checkVal("a.parity_err_sticky", {31'd0, sticky_a}, {31'd0, m_sticky[0]});
        checkVal("a.frame_count",       {16'd0, fc_a},     m_fc[0]);
        checkVal("a.err_count",         {16'd0, ec_a},     m_ec[0]);
        checkVal("b.debug_frame",       {23'd0, dbg_b},    {23'd0, m_frame[1]});
        checkVal("b.frame_strobe",      {31'd0, strobe_b}, {31'd0, m_strobe[1]});
        checkVal("b.parity_ok",         {31'd0, ok_b},     {31'd0, m_ok[1]});
        checkVal("b.parity_err_sticky", {31'd0, sticky_b}, {31'd0, m_sticky[1]});
        checkVal("b.frame_count",       {28'd0, fc_b},     m_fc[1]);
        checkVal("b.err_count",         {28'd0, ec_b},     m_ec[1]);
    endtask

    // Drive one cycle of inputs well away from the edge, then check 1 ns after the edge
    task automatic applyStimulus(input logic rst_v, input logic valid_v, input logic [8:0] frame_v);
        rst         = rst_v;
        frame_valid = valid_v;
        frame       = frame_v;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        logic       rnd_rst;
        logic       rnd_valid;
        logic [8:0] rnd_frame;

        rst         = 1'b1;
        frame_valid = 1'b0;
        frame       = 9'h000;
        for (int i = 0; i < 2; i++) begin
            m_frame[i]  = 9'h000;
            m_strobe[i] = 1'b0;
            m_ok[i]     = 1'b1;
            m_sticky[i] = 1'b0;
            m_fc[i]     = 0;
            m_ec[i]     = 0;
        end

        $display("[TB] reset with a valid frame present");
        applyStimulus(1'b1, 1'b1, 9'h1FF);
        checkVal("reset.frame_count", {16'd0, fc_a}, 32'd0);
        checkVal("reset.debug_frame", {23'd0, dbg_a}, 32'd0);
        checkVal("reset.parity_ok", {31'd0, ok_a}, 32'd1);

        $display("[TB] good frame right after reset release");
        applyStimulus(1'b0, 1'b1, 9'h0AA);
        checkVal("good.debug_frame", {23'd0, dbg_a}, 32'h0AA);
        checkVal("good.strobe", {31'd0, strobe_a}, 32'd1);
        checkVal("good.parity_ok", {31'd0, ok_a}, 32'd1);
        checkVal("good.frame_count", {16'd0, fc_a}, 32'd1);
        checkVal("good.err_count", {16'd0, ec_a}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 9'($urandom));
        end
        checkVal("idle.strobe", {31'd0, strobe_a}, 32'd0);

        $display("[TB] bad parity frame");
        applyStimulus(1'b0, 1'b1, 9'h0B3);
        checkVal("bad.debug_frame", {23'd0, dbg_a}, 32'h0B3);
        checkVal("bad.parity_ok", {31'd0, ok_a}, 32'd0);
        checkVal("bad.sticky", {31'd0, sticky_a}, 32'd1);
        checkVal("bad.frame_count", {16'd0, fc_a}, 32'd2);
        checkVal("bad.err_count", {16'd0, ec_a}, 32'd1);

        $display("[TB] hold while frame_valid is low");
        applyStimulus(1'b0, 1'b0, 9'h155);
        checkVal("hold.debug_frame", {23'd0, dbg_a}, 32'h0B3);
        checkVal("hold.strobe", {31'd0, strobe_a}, 32'd0);
        applyStimulus(1'b0, 1'b1, 9'h0AA);
        checkVal("recover.parity_ok", {31'd0, ok_a}, 32'd1);
        checkVal("recover.sticky", {31'd0, sticky_a}, 32'd1);

        $display("[TB] back-to-back frames");
        applyStimulus(1'b0, 1'b1, 9'h101);
        checkVal("b2b1.debug_frame", {23'd0, dbg_a}, 32'h101);
        applyStimulus(1'b0, 1'b1, 9'h102);
        checkVal("b2b2.debug_frame", {23'd0, dbg_a}, 32'h102);
        checkVal("b2b2.strobe", {31'd0, strobe_a}, 32'd1);
        applyStimulus(1'b0, 1'b1, 9'h003);
        checkVal("b2b3.debug_frame", {23'd0, dbg_a}, 32'h003);
        checkVal("b2b3.frame_count", {16'd0, fc_a}, 32'd6);
        checkVal("b2b3.err_count", {16'd0, ec_a}, 32'd1);
        applyStimulus(1'b0, 1'b0, 9'h000);

        $display("[TB] saturation of the 4-bit counters");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 9'($urandom));
        end
        checkVal("sat.frame_count_b", {28'd0, fc_b}, 32'd15);

        $display("[TB] odd parity frame");
        applyStimulus(1'b0, 1'b1, 9'h1AA);
        checkVal("odd.parity_ok_b", {31'd0, ok_b}, 32'd1);
        checkVal("odd.parity_ok_a", {31'd0, ok_a}, 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rnd_rst   = ($urandom_range(0, 59) == 0);
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd_frame = 9'($urandom);
            applyStimulus(rnd_rst, rnd_valid, rnd_frame);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
